hsv_core_ctrlstatus_regfile: RTL and testbench
==============================================

// Module: hsv_core_ctrlstatus_regfile
// PURPOSE
//  Responder end of the CSR register request interface driven by the ctrlstatus execution unit.
//  Decodes regs_addr, performs bit-enabled reads/writes on machine-mode CSRs, and returns
//  single-cycle rd/wr acks with error flags. Also owns the mcycle/minstret counters.
//  Exports live trap-related CSR values to the rest of the core.
// PARAMETERS
//  HART_ID      0             value returned by mhartid (0xF14)
//  MISA_VALUE   32'h4000_0100 RV32I constant returned by misa (0x301)
// PORTS
//  clk_core           in   1   core clock
//  rst_core_n         in   1   async active-low reset
//  regs_req           in   1   request strobe, accepted when the matching stall is low
//  regs_req_is_wr     in   1   1 = write, 0 = read
//  regs_addr          in   16  {csr_num[11:0], 4'b0000}
//  regs_wr_data       in   32  write data
//  regs_wr_biten      in   32  per-bit write enable
//  regs_req_stall_wr  out  1   write request not accepted this cycle
//  regs_req_stall_rd  out  1   read request not accepted this cycle
//  regs_rd_ack        out  1   one-cycle read response pulse
//  regs_rd_err        out  1   read error, valid with rd_ack
//  regs_rd_data       out  32  read data, valid with rd_ack
//  regs_wr_ack        out  1   one-cycle write response pulse
//  regs_wr_err        out  1   write error, valid with wr_ack
//  retire_valid       in   1   one instruction retired this cycle (minstret increment)
//  mstatus_mie        out  1   mstatus.MIE
//  mtvec_base         out  32  {mtvec[31:2], 2'b00}
//  mepc_value         out  32  mepc
// BEHAVIOUR
//  - Accept: regs_req & ~stall (stall_wr for writes, stall_rd for reads). Response in cycle N+1:
//    exactly one of rd_ack/wr_ack pulses for one cycle.
//  - pending flag = set on accept, cleared next cycle. stall_rd = stall_wr = pending.
//    Back-to-back requests therefore issue at most every other cycle.
//  - Reset: all ack/err/data outputs 0, pending 0, stalls 0; mstatus=0, mie=0, mtvec=0,
//    mscratch=0, mepc=0, mcause=0, mtval=0, counters=0.
//  - Write update: new = (old & ~biten) | (wr_data & biten), then WARL masking; takes
//    effect at accept edge. A read issued after the write's ack returns the new value.
//  - CSR map (csr_num):
//    0x300 mstatus: only MIE[3], MPIE[7], MPP[12:11] writable; MPP reads 2'b11. Other bits 0.
//    0x301 misa:    reads MISA_VALUE; writes acked, ignored, no error (WARL).
//    0x304 mie:     bits 3, 7, 11 writable, others 0.
//    0x305 mtvec:   bits[1:0] forced 00 (direct mode only).
//    0x340 mscratch: full 32 bits.
//    0x341 mepc:    bits[1:0] forced 00.
//    0x342 mcause, 0x343 mtval: full 32 bits.
//    0x344 mip:     reads 0, writes acked and ignored.
//    0xB00/0xB80 mcycle/mcycleh, 0xB02/0xB82 minstret/minstreth: read-write.
//    0xC00/0xC80/0xC02/0xC82: read-only shadows of the same counters.
//    0xF11-0xF14 mvendorid/marchid/mimpid/mhartid: read-only; mhartid = HART_ID, others 0.
//  - Errors (ack still pulses; data 0 on read error; no state change on write error):
//    unmapped csr_num; regs_addr[3:0] != 0; write to csr_num[11:10] == 2'b11.
//  - Counters are 64 bit. mcycle increments every cycle; minstret increments on retire_valid.
//    Carry propagates low->high with 32-bit wrap: 0xFFFF_FFFF -> low 0, high +1;
//    all-ones -> 0. A write to either half on a cycle wins over that cycle's increment for
//    the whole counter. A write to one half leaves the other half unchanged.
//  - Reset mid-operation: pending request and its ack are dropped, no ack is emitted.
// CONFIGURATION
//  HSV_CTRLSTATUS_COUNTERS_EN defined: counters implemented as above.
//  Not defined: no counter flops; all counter addresses read 0, writes acked, no error.
//  retire_valid is ignored.
// TESTING
//  - Write 0x340 data 0xDEAD_BEEF biten '1, then read 0x340 -> wr_ack err=0; rd_data 0xDEAD_BEEF.
//  - mscratch=0xFFFF_0000, write data 0x0000_1234 biten 0x0000_FFFF -> readback 0xFFFF_1234.
//  - Write 0x305 0x8000_0003 -> readback 0x8000_0000; mtvec_base 0x8000_0000.
//  - Read 0x7C0 -> rd_ack, err=1, data 0. Write 0xC00 -> wr_err=1, counter unchanged.
//  - Request in cycle N, second request in N+1 -> stall high in N+1; second accepted N+2.
//  - (_EN) write mcycle 0xFFFF_FFFF, mcycleh 0 -> 2 cycles later mcycleh reads 1.

Source files
------------

// File: rtl/hsv_core_ctrlstatus_regfile.sv
// hsv_core_ctrlstatus_regfile
// Machine-mode CSR responder for the ctrlstatus execution unit.
// Requests are accepted when not stalled and answered with a one-cycle
// rd/wr ack in the following cycle.
// Optional feature macro: HSV_CTRLSTATUS_COUNTERS_EN enables the 64-bit
// mcycle/minstret counters. Without it, counter addresses read 0 and
// writes to them are acked without effect.
module hsv_core_ctrlstatus_regfile #(
    parameter logic [31:0] HART_ID    = 32'd0,
    parameter logic [31:0] MISA_VALUE = 32'h4000_0100
) (
    input  logic        clk_core,
    input  logic        rst_core_n,
    input  logic        regs_req,
    input  logic        regs_req_is_wr,
    input  logic [15:0] regs_addr,
    input  logic [31:0] regs_wr_data,
    input  logic [31:0] regs_wr_biten,
    output logic        regs_req_stall_wr,
    output logic        regs_req_stall_rd,
    output logic        regs_rd_ack,
    output logic        regs_rd_err,
    output logic [31:0] regs_rd_data,
    output logic        regs_wr_ack,
    output logic        regs_wr_err,
    input  logic        retire_valid,
    output logic        mstatus_mie,
    output logic [31:0] mtvec_base,
    output logic [31:0] mepc_value
);

    logic        pending;
    logic        accept;
    logic [11:0] csr_num;
    logic        addr_ok;
    logic        mapped;
    logic [31:0] csr_rdata;
    logic        rd_err_c;
    logic        wr_err_c;
    logic [31:0] wr_merged;
    logic        wr_en;

    logic        status_mie;
    logic        status_mpie;
    logic [31:0] mie_en;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;

`ifdef HSV_CTRLSTATUS_COUNTERS_EN
    logic [63:0] mcycle;
    logic [63:0] minstret;
`else
    logic        unused_retire;
    assign unused_retire = retire_valid;
`endif

    assign csr_num           = regs_addr[15:4];
    assign addr_ok           = (regs_addr[3:0] == 4'h0);
    assign regs_req_stall_wr = pending;
    assign regs_req_stall_rd = pending;
    assign accept            = regs_req & ~pending;

    assign rd_err_c  = ~mapped | ~addr_ok;
    assign wr_err_c  = ~mapped | ~addr_ok | (csr_num[11:10] == 2'b11);
    assign wr_merged = (csr_rdata & ~regs_wr_biten) | (regs_wr_data & regs_wr_biten);
    assign wr_en     = accept & regs_req_is_wr & ~wr_err_c;

    assign mstatus_mie = status_mie;
    assign mtvec_base  = {mtvec[31:2], 2'b00};
    assign mepc_value  = mepc;

    // Address decode and read mux; csr_rdata also serves as the old value for bit-enabled writes
    always_comb begin
        csr_rdata = '0;
        mapped    = 1'b1;
        case (csr_num)
            12'h300: csr_rdata = {19'b0, 2'b11, 3'b0, status_mpie, 3'b0, status_mie, 3'b0};
            12'h301: csr_rdata = MISA_VALUE;
            12'h304: csr_rdata = mie_en;
            12'h305: csr_rdata = mtvec;
            12'h340: csr_rdata = mscratch;
            12'h341: csr_rdata = mepc;
            12'h342: csr_rdata = mcause;
            12'h343: csr_rdata = mtval;
            12'h344: csr_rdata = '0;
`ifdef HSV_CTRLSTATUS_COUNTERS_EN
            12'hB00, 12'hC00: csr_rdata = mcycle[31:0];
            12'hB80, 12'hC80: csr_rdata = mcycle[63:32];
            12'hB02, 12'hC02: csr_rdata = minstret[31:0];
            12'hB82, 12'hC82: csr_rdata = minstret[63:32];
`else
            12'hB00, 12'hB80, 12'hB02, 12'hB82,
            12'hC00, 12'hC80, 12'hC02, 12'hC82: csr_rdata = '0;
`endif
            12'hF11, 12'hF12, 12'hF13: csr_rdata = '0;
            12'hF14: csr_rdata = HART_ID;
            default: mapped = 1'b0;
        endcase
    end

    // Request handshake: one outstanding request, answered the following cycle
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            pending      <= 1'b0;
            regs_rd_ack  <= 1'b0;
            regs_rd_err  <= 1'b0;
            regs_rd_data <= '0;
            regs_wr_ack  <= 1'b0;
            regs_wr_err  <= 1'b0;
        end else begin
            pending      <= accept;
            regs_rd_ack  <= accept & ~regs_req_is_wr;
            regs_rd_err  <= accept & ~regs_req_is_wr & rd_err_c;
            regs_rd_data <= (accept && !regs_req_is_wr && !rd_err_c) ? csr_rdata : '0;
            regs_wr_ack  <= accept & regs_req_is_wr;
            regs_wr_err  <= accept & regs_req_is_wr & wr_err_c;
        end
    end

    // Trap CSR storage with WARL masking applied on write
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            status_mie  <= 1'b0;
            status_mpie <= 1'b0;
            mie_en      <= '0;
            mtvec       <= '0;
            mscratch    <= '0;
            mepc        <= '0;
            mcause      <= '0;
            mtval       <= '0;
        end else if (wr_en) begin
            case (csr_num)
                12'h300: begin
                    status_mie  <= wr_merged[3];
                    status_mpie <= wr_merged[7];
                end
                12'h304: mie_en   <= wr_merged & 32'h0000_0888;
                12'h305: mtvec    <= {wr_merged[31:2], 2'b00};
                12'h340: mscratch <= wr_merged;
                12'h341: mepc     <= {wr_merged[31:2], 2'b00};
                12'h342: mcause   <= wr_merged;
                12'h343: mtval    <= wr_merged;
                default: ;
            endcase
        end
    end

`ifdef HSV_CTRLSTATUS_COUNTERS_EN
    // 64-bit counters; a write to either half suppresses that cycle's increment
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (wr_en && csr_num == 12'hB00)
                mcycle <= {mcycle[63:32], wr_merged};
            else if (wr_en && csr_num == 12'hB80)
                mcycle <= {wr_merged, mcycle[31:0]};
            else
                mcycle <= mcycle + 64'd1;

            if (wr_en && csr_num == 12'hB02)
                minstret <= {minstret[63:32], wr_merged};
            else if (wr_en && csr_num == 12'hB82)
                minstret <= {wr_merged, minstret[31:0]};
            else if (retire_valid)
                minstret <= minstret + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hsv_core_ctrlstatus_regfile.sv
// Directed self-checking bench for hsv_core_ctrlstatus_regfile.
module tb_hsv_core_ctrlstatus_regfile;

    logic        clk;
    logic        rst_n;
    logic        regs_req;
    logic        regs_req_is_wr;
    logic [15:0] regs_addr;
    logic [31:0] regs_wr_data;
    logic [31:0] regs_wr_biten;
    logic        regs_req_stall_wr;
    logic        regs_req_stall_rd;
    logic        regs_rd_ack;
    logic        regs_rd_err;
    logic [31:0] regs_rd_data;
    logic        regs_wr_ack;
    logic        regs_wr_err;
    logic        retire_valid;
    logic        mstatus_mie;
    logic [31:0] mtvec_base;
    logic [31:0] mepc_value;

    int errors = 0;
    int checks = 0;

    hsv_core_ctrlstatus_regfile #(
        .HART_ID    (32'd5),
        .MISA_VALUE (32'h4000_0100)
    ) dut (
        .clk_core          (clk),
        .rst_core_n        (rst_n),
        .regs_req          (regs_req),
        .regs_req_is_wr    (regs_req_is_wr),
        .regs_addr         (regs_addr),
        .regs_wr_data      (regs_wr_data),
        .regs_wr_biten     (regs_wr_biten),
        .regs_req_stall_wr (regs_req_stall_wr),
        .regs_req_stall_rd (regs_req_stall_rd),
        .regs_rd_ack       (regs_rd_ack),
        .regs_rd_err       (regs_rd_err),
        .regs_rd_data      (regs_rd_data),
        .regs_wr_ack       (regs_wr_ack),
        .regs_wr_err       (regs_wr_err),
        .retire_valid      (retire_valid),
        .mstatus_mie       (mstatus_mie),
        .mtvec_base        (mtvec_base),
        .mepc_value        (mepc_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one write, sample the ack one cycle later, then let pending clear
    task automatic do_write(input logic [15:0] addr, input logic [31:0] data,
                            input logic [31:0] biten, output logic ack, output logic err);
        int unsigned n = 0;
        @(negedge clk);
        while (regs_req_stall_wr && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (regs_req_stall_wr) begin
            checks++;
            errors++;
            $display("FAIL wr_stall_timeout addr=%h stall stayed 1, required 0", addr);
        end
        regs_req       = 1'b1;
        regs_req_is_wr = 1'b1;
        regs_addr      = addr;
        regs_wr_data   = data;
        regs_wr_biten  = biten;
        @(posedge clk);
        #1;
        regs_req = 1'b0;
        ack = regs_wr_ack;
        err = regs_wr_err;
        @(posedge clk);
        #1;
    endtask

    // Drive one read, sample ack/err/data one cycle later, then let pending clear
    task automatic do_read(input logic [15:0] addr, output logic ack, output logic err,
                           output logic [31:0] data);
        int unsigned n = 0;
        @(negedge clk);
        while (regs_req_stall_rd && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (regs_req_stall_rd) begin
            checks++;
            errors++;
            $display("FAIL rd_stall_timeout addr=%h stall stayed 1, required 0", addr);
        end
        regs_req       = 1'b1;
        regs_req_is_wr = 1'b0;
        regs_addr      = addr;
        @(posedge clk);
        #1;
        regs_req = 1'b0;
        ack  = regs_rd_ack;
        err  = regs_rd_err;
        data = regs_rd_data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        regs_req = 1'b0; regs_req_is_wr = 1'b0; regs_addr = '0;
        regs_wr_data = '0; regs_wr_biten = '0; retire_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (regs_rd_ack !== 1'b0) begin errors++; $display("FAIL reset_rd_ack got %b exp 0", regs_rd_ack); end
        checks++; if (regs_wr_ack !== 1'b0) begin errors++; $display("FAIL reset_wr_ack got %b exp 0", regs_wr_ack); end
        checks++; if (regs_rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", regs_rd_data); end
        checks++; if (regs_req_stall_rd !== 1'b0) begin errors++; $display("FAIL reset_stall_rd got %b exp 0", regs_req_stall_rd); end
        checks++; if (regs_req_stall_wr !== 1'b0) begin errors++; $display("FAIL reset_stall_wr got %b exp 0", regs_req_stall_wr); end
        checks++; if (mtvec_base !== 32'h0) begin errors++; $display("FAIL reset_mtvec got %h exp 0", mtvec_base); end
        checks++; if (mepc_value !== 32'h0) begin errors++; $display("FAIL reset_mepc got %h exp 0", mepc_value); end
        checks++; if (mstatus_mie !== 1'b0) begin errors++; $display("FAIL reset_mie got %b exp 0", mstatus_mie); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mscratch();
        logic ack, err;
        logic [31:0] d;
        do_write(16'h3400, 32'hDEAD_BEEF, 32'hFFFF_FFFF, ack, err);
        checks++; if (ack !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL mscratch_wr ack/err got %b/%b exp 1/0", ack, err); end
        do_read(16'h3400, ack, err, d);
        checks++; if (ack !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL mscratch_rd ack/err got %b/%b exp 1/0", ack, err); end
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mscratch_rd data got %h exp DEADBEEF", d); end
        do_write(16'h3400, 32'hFFFF_0000, 32'hFFFF_FFFF, ack, err);
        do_write(16'h3400, 32'h0000_1234, 32'h0000_FFFF, ack, err);
        do_read(16'h3400, ack, err, d);
        checks++; if (d !== 32'hFFFF_1234) begin errors++; $display("FAIL mscratch_biten got %h exp FFFF1234", d); end
    endtask

    task automatic test_trap_csrs();
        logic ack, err;
        logic [31:0] d;
        do_write(16'h3050, 32'h8000_0003, 32'hFFFF_FFFF, ack, err);
        do_read(16'h3050, ack, err, d);
        checks++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL mtvec_rd got %h exp 80000000", d); end
        checks++; if (mtvec_base !== 32'h8000_0000) begin errors++; $display("FAIL mtvec_base got %h exp 80000000", mtvec_base); end
        do_write(16'h3410, 32'h1234_5677, 32'hFFFF_FFFF, ack, err);
        do_read(16'h3410, ack, err, d);
        checks++; if (d !== 32'h1234_5674) begin errors++; $display("FAIL mepc_rd got %h exp 12345674", d); end
        checks++; if (mepc_value !== 32'h1234_5674) begin errors++; $display("FAIL mepc_value got %h exp 12345674", mepc_value); end
        do_write(16'h3000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ack, err);
        do_read(16'h3000, ack, err, d);
        checks++; if (d !== 32'h0000_1888) begin errors++; $display("FAIL mstatus_rd got %h exp 00001888", d); end
        checks++; if (mstatus_mie !== 1'b1) begin errors++; $display("FAIL mstatus_mie got %b exp 1", mstatus_mie); end
        do_write(16'h3000, 32'h0000_0000, 32'h0000_0008, ack, err);
        do_read(16'h3000, ack, err, d);
        checks++; if (d !== 32'h0000_1880) begin errors++; $display("FAIL mstatus_clr got %h exp 00001880", d); end
        checks++; if (mstatus_mie !== 1'b0) begin errors++; $display("FAIL mstatus_mie_clr got %b exp 0", mstatus_mie); end
        do_write(16'h3040, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ack, err);
        do_read(16'h3040, ack, err, d);
        checks++; if (d !== 32'h0000_0888) begin errors++; $display("FAIL mie_rd got %h exp 00000888", d); end
        do_write(16'h3420, 32'hA5A5_0001, 32'hFFFF_FFFF, ack, err);
        do_read(16'h3420, ack, err, d);
        checks++; if (d !== 32'hA5A5_0001) begin errors++; $display("FAIL mcause_rd got %h exp A5A50001", d); end
    endtask

    task automatic test_const_csrs();
        logic ack, err;
        logic [31:0] d;
        do_write(16'h3010, 32'h0, 32'hFFFF_FFFF, ack, err);
        checks++; if (ack !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL misa_wr ack/err got %b/%b exp 1/0", ack, err); end
        do_read(16'h3010, ack, err, d);
        checks++; if (d !== 32'h4000_0100) begin errors++; $display("FAIL misa_rd got %h exp 40000100", d); end
        do_write(16'h3440, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ack, err);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mip_wr err got %b exp 0", err); end
        do_read(16'h3440, ack, err, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL mip_rd got %h exp 0", d); end
        do_read(16'hF140, ack, err, d);
        checks++; if (d !== 32'h5 || err !== 1'b0) begin errors++; $display("FAIL mhartid got %h err %b exp 5 err 0", d, err); end
        do_read(16'hF110, ack, err, d);
        checks++; if (d !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL mvendorid got %h err %b exp 0 err 0", d, err); end
        do_write(16'hF140, 32'h1, 32'hFFFF_FFFF, ack, err);
        checks++; if (ack !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL mhartid_wr ack/err got %b/%b exp 1/1", ack, err); end
    endtask

    task automatic test_errors();
        logic ack, err;
        logic [31:0] d;
        do_read(16'h7C00, ack, err, d);
        checks++; if (ack !== 1'b1 || err !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL unmapped_rd ack %b err %b data %h exp 1 1 0", ack, err, d); end
        do_write(16'h7C00, 32'h1, 32'hFFFF_FFFF, ack, err);
        checks++; if (ack !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL unmapped_wr ack/err got %b/%b exp 1/1", ack, err); end
        do_read(16'h3404, ack, err, d);
        checks++; if (err !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL lowaddr_rd err %b data %h exp 1 0", err, d); end
        do_write(16'h3408, 32'h0, 32'hFFFF_FFFF, ack, err);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL lowaddr_wr err got %b exp 1", err); end
        do_read(16'h3400, ack, err, d);
        checks++; if (d !== 32'hFFFF_1234) begin errors++; $display("FAIL lowaddr_nochange got %h exp FFFF1234", d); end
    endtask

    task automatic test_counters();
        logic ack, err;
        logic [31:0] d;
        do_write(16'hC000, 32'h0, 32'hFFFF_FFFF, ack, err);
        checks++; if (ack !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL cycle_ro_wr ack/err got %b/%b exp 1/1", ack, err); end
`ifdef HSV_CTRLSTATUS_COUNTERS_EN
        do_write(16'hB000, 32'd100, 32'hFFFF_FFFF, ack, err);
        do_read(16'hB000, ack, err, d);
        checks++; if (d !== 32'd101) begin errors++; $display("FAIL mcycle_wr_wins got %0d exp 101", d); end
        do_write(16'hB800, 32'h0, 32'hFFFF_FFFF, ack, err);
        do_write(16'hB000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ack, err);
        do_read(16'hB800, ack, err, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL mcycleh_carry got %h exp 1", d); end
        do_read(16'hB000, ack, err, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL mcycle_wrap got %h exp 2", d); end
        do_write(16'hB020, 32'h0, 32'hFFFF_FFFF, ack, err);
        do_write(16'hB820, 32'h0, 32'hFFFF_FFFF, ack, err);
        @(negedge clk);
        retire_valid = 1'b1;
        repeat (3) @(negedge clk);
        retire_valid = 1'b0;
        do_read(16'hC020, ack, err, d);
        checks++; if (d !== 32'd3 || err !== 1'b0) begin errors++; $display("FAIL minstret got %0d err %b exp 3 err 0", d, err); end
        do_write(16'hC020, 32'h55, 32'hFFFF_FFFF, ack, err);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL instret_ro_wr err got %b exp 1", err); end
        do_read(16'hB020, ack, err, d);
        checks++; if (d !== 32'd3) begin errors++; $display("FAIL minstret_unchanged got %0d exp 3", d); end
`else
        do_read(16'hB000, ack, err, d);
        checks++; if (ack !== 1'b1 || err !== 1'b0 || d !== 32'h0) begin errors++; $display("FAIL mcycle_off ack %b err %b data %h exp 1 0 0", ack, err, d); end
        do_write(16'hB000, 32'h1234, 32'hFFFF_FFFF, ack, err);
        checks++; if (ack !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL mcycle_off_wr ack/err got %b/%b exp 1/0", ack, err); end
        do_read(16'hB000, ack, err, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL mcycle_off_rd got %h exp 0", d); end
        do_read(16'hC820, ack, err, d);
        checks++; if (d !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL instreth_off got %h err %b exp 0 0", d, err); end
`endif
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        regs_req = 1'b1; regs_req_is_wr = 1'b0; regs_addr = 16'h3400;
        @(posedge clk);
        #1;
        checks++; if (regs_rd_ack !== 1'b1 || regs_rd_data !== 32'hFFFF_1234) begin errors++; $display("FAIL b2b_first ack %b data %h exp 1 FFFF1234", regs_rd_ack, regs_rd_data); end
        checks++; if (regs_req_stall_rd !== 1'b1 || regs_req_stall_wr !== 1'b1) begin errors++; $display("FAIL b2b_stall got %b/%b exp 1/1", regs_req_stall_rd, regs_req_stall_wr); end
        regs_addr = 16'h3050;
        @(posedge clk);
        #1;
        checks++; if (regs_rd_ack !== 1'b0 || regs_req_stall_rd !== 1'b0) begin errors++; $display("FAIL b2b_gap ack %b stall %b exp 0 0", regs_rd_ack, regs_req_stall_rd); end
        @(posedge clk);
        #1;
        regs_req = 1'b0;
        checks++; if (regs_rd_ack !== 1'b1 || regs_rd_data !== 32'h8000_0000) begin errors++; $display("FAIL b2b_second ack %b data %h exp 1 80000000", regs_rd_ack, regs_rd_data); end
        @(posedge clk);
        #1;
        checks++; if (regs_rd_ack !== 1'b0) begin errors++; $display("FAIL b2b_single_pulse ack got %b exp 0", regs_rd_ack); end
    endtask

    task automatic test_reset_mid_op();
        logic ack, err;
        logic [31:0] d;
        @(negedge clk);
        regs_req = 1'b1; regs_req_is_wr = 1'b1; regs_addr = 16'h3400;
        regs_wr_data = 32'h0000_0001; regs_wr_biten = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        regs_req = 1'b0;
        checks++; if (regs_wr_ack !== 1'b1) begin errors++; $display("FAIL midrst_pre ack got %b exp 1", regs_wr_ack); end
        rst_n = 1'b0;
        #1;
        checks++; if (regs_wr_ack !== 1'b0 || regs_req_stall_wr !== 1'b0) begin errors++; $display("FAIL midrst_drop ack %b stall %b exp 0 0", regs_wr_ack, regs_req_stall_wr); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (regs_wr_ack !== 1'b0 || regs_rd_ack !== 1'b0) begin errors++; $display("FAIL midrst_noack wr %b rd %b exp 0 0", regs_wr_ack, regs_rd_ack); end
        do_read(16'h3400, ack, err, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrst_cleared got %h exp 0", d); end
    endtask

    initial begin
        test_reset();
        test_mscratch();
        test_trap_csrs();
        test_const_csrs();
        test_errors();
        test_counters();
        test_back_to_back();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
